// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for a 5-stage RISC-V core.
// It detects load-use hazards and inserts a one-cycle bubble for them.
// It also flushes EX contents on a taken branch, jump or mret.
// Optional feature: define ID_EX_STALL_CNT_EN to build a saturating
// counter of load-use stall cycles. When it is undefined, stall_count is 0.
module id_ex_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [19:0] id_ctrl,
   input  logic [31:0] id_pc,
   input  logic [4:0]  id_rs1_addr,
   input  logic [4:0]  id_rs2_addr,
   input  logic [4:0]  id_rd_addr,
   input  logic [31:0] id_rs1_data,
   input  logic [31:0] id_rs2_data,
   input  logic [31:0] id_imm,
   input  logic        ex_flush,
   output logic        stall,
   output logic        ex_valid,
   output logic [19:0] ex_ctrl,
   output logic [31:0] ex_pc,
   output logic [31:0] ex_imm,
   output logic [31:0] ex_rs1_data,
   output logic [31:0] ex_rs2_data,
   output logic [4:0]  ex_rs1_addr,
   output logic [4:0]  ex_rs2_addr,
   output logic [4:0]  ex_rd_addr,
   output logic [31:0] stall_count
);

   // Bit position of memRdEn inside the decoder control bundle.
   localparam int CTRL_MEMRD_BIT = 6;

   logic haz_s;

   // Load-use hazard: the EX load targets a register that the ID instruction may read.
   // The check does not know whether ID really uses rs1/rs2, so it is conservative.
   always_comb begin
      haz_s = 1'b0;
      if (ex_valid && ex_ctrl[CTRL_MEMRD_BIT] && (ex_rd_addr != 5'd0) && id_valid &&
          ((ex_rd_addr == id_rs1_addr) || (ex_rd_addr == id_rs2_addr))) begin
         haz_s = 1'b1;
      end else begin
         haz_s = 1'b0;
      end
   end

   // A flush kills the ID instruction, so a stall is pointless in that case.
   assign stall = haz_s & ~ex_flush;

   // Pipeline register: data fields always load, and the valid/ctrl priority is flush, then hazard, then normal.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid    <= 1'b0;
         ex_ctrl     <= 20'd0;
         ex_pc       <= 32'd0;
         ex_imm      <= 32'd0;
         ex_rs1_data <= 32'd0;
         ex_rs2_data <= 32'd0;
         ex_rs1_addr <= 5'd0;
         ex_rs2_addr <= 5'd0;
         ex_rd_addr  <= 5'd0;
      end else begin
         ex_pc       <= id_pc;
         ex_imm      <= id_imm;
         ex_rs1_data <= id_rs1_data;
         ex_rs2_data <= id_rs2_data;
         ex_rs1_addr <= id_rs1_addr;
         ex_rs2_addr <= id_rs2_addr;
         ex_rd_addr  <= id_rd_addr;
         if (ex_flush || haz_s) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= 20'd0;
         end else begin
            ex_valid <= id_valid;
            ex_ctrl  <= id_valid ? id_ctrl : 20'd0;
         end
      end
   end

`ifdef ID_EX_STALL_CNT_EN
   logic [31:0] stall_cnt_r;

   // Count load-use stall cycles and hold the value at the maximum. Only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_r <= 32'd0;
      end else if (stall && (stall_cnt_r != 32'hFFFF_FFFF)) begin
         stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign stall_count = stall_cnt_r;
`else
   assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage. It uses a reference model and a scoreboard queue.
// The expected EX contents are pushed when stimulus is driven. They are popped and compared after the edge.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [19:0] id_ctrl;
   logic [31:0] id_pc;
   logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic [31:0] id_rs1_data, id_rs2_data, id_imm;
   logic        ex_flush;
   logic        stall;
   logic        ex_valid;
   logic [19:0] ex_ctrl;
   logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
   logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
   logic [31:0] stall_count;

   typedef struct packed {
      logic        valid;
      logic [19:0] ctrl;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [4:0]  rd_addr;
   } exp_t;

   exp_t sbq[$];

   // Model copy of the EX slot, used to predict hazards.
   logic        m_valid;
   logic [19:0] m_ctrl;
   logic [4:0]  m_rd;
   int          m_stalls;

   int checks = 0;
   int errors = 0;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc(id_pc),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .ex_flush(ex_flush), .stall(stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
      .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
      .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
      .stall_count(stall_count)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_count();
`ifdef ID_EX_STALL_CNT_EN
      return m_stalls;
`else
      return 32'd0;
`endif
   endfunction

   task automatic set_id(input logic v, input logic [19:0] c, input logic [31:0] pc,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic fl);
      id_valid    = v;
      id_ctrl     = c;
      id_pc       = pc;
      id_rs1_addr = rs1;
      id_rs2_addr = rs2;
      id_rd_addr  = rd;
      id_rs1_data = $urandom;
      id_rs2_data = $urandom;
      id_imm      = $urandom;
      ex_flush    = fl;
   endtask

   // Checks the outputs while reset is held. Reset is released before the next edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_valid", {31'd0, ex_valid}, 32'd0);
      check("rst_ctrl", {12'd0, ex_ctrl}, 32'd0);
      check("rst_pc", ex_pc, 32'd0);
      check("rst_data", ex_rs1_data | ex_rs2_data | ex_imm, 32'd0);
      check("rst_addr", {17'd0, ex_rs1_addr, ex_rs2_addr, ex_rd_addr}, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_cnt", stall_count, 32'd0);
      rst_n = 1'b1;
      m_valid  = 1'b0;
      m_ctrl   = 20'd0;
      m_rd     = 5'd0;
      m_stalls = 0;
      sbq.delete();
   endtask

   // One clock: predict the stall, push the expected EX state, clock, then pop and compare.
   task automatic cycle(output logic stalled);
      exp_t e;
      logic h;
      #1;
      h = m_valid && m_ctrl[6] && (m_rd != 5'd0) && id_valid &&
          ((m_rd == id_rs1_addr) || (m_rd == id_rs2_addr));
      check("stall", {31'd0, stall}, {31'd0, h && !ex_flush});
      e.valid    = (h || ex_flush) ? 1'b0 : id_valid;
      e.ctrl     = e.valid ? id_ctrl : 20'd0;
      e.pc       = id_pc;
      e.imm      = id_imm;
      e.rs1_data = id_rs1_data;
      e.rs2_data = id_rs2_data;
      e.rs1_addr = id_rs1_addr;
      e.rs2_addr = id_rs2_addr;
      e.rd_addr  = id_rd_addr;
      sbq.push_back(e);
      stalled = h && !ex_flush;
      if (stalled) m_stalls++;
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      check("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
      check("ex_ctrl", {12'd0, ex_ctrl}, {12'd0, e.ctrl});
      check("ex_pc", ex_pc, e.pc);
      check("ex_imm", ex_imm, e.imm);
      check("ex_rs1_data", ex_rs1_data, e.rs1_data);
      check("ex_rs2_data", ex_rs2_data, e.rs2_data);
      check("ex_addrs", {17'd0, ex_rs1_addr, ex_rs2_addr, ex_rd_addr},
            {17'd0, e.rs1_addr, e.rs2_addr, e.rd_addr});
      check("stall_count", stall_count, exp_count());
      m_valid = e.valid;
      m_ctrl  = e.ctrl;
      m_rd    = e.rd_addr;
   endtask

   localparam logic [19:0] LW  = 20'h00140; // regWrite + memRdEn
   localparam logic [19:0] ADD = 20'h00100; // regWrite only

   initial begin
      logic st;
      rst_n = 1'b0;
      set_id(1'b0, 20'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
      #3;
      do_reset();

      // Normal load: the result appears in EX one cycle later.
      set_id(1'b1, 20'h0A5C3, 32'h100, 5'd1, 5'd2, 5'd0, 1'b0);
      cycle(st);
      check("norm_valid", {31'd0, ex_valid}, 32'd1);
      check("norm_ctrl", {12'd0, ex_ctrl}, 32'h0A5C3);
      check("norm_pc", ex_pc, 32'h100);

      // Load-use: lw x5, then add rs1=x5. Expect one bubble, then the add enters EX.
      set_id(1'b1, LW, 32'h104, 5'd1, 5'd2, 5'd5, 1'b0);
      cycle(st);
      set_id(1'b1, ADD, 32'h108, 5'd5, 5'd3, 5'd6, 1'b0);
      #1;
      check("lu_stall_hi", {31'd0, stall}, 32'd1);
      cycle(st);
      check("lu_bubble", {11'd0, ex_valid, ex_ctrl}, 32'd0);
      cycle(st);
      check("lu_add_in", {11'd0, ex_valid, ex_ctrl}, {11'd0, 1'b1, ADD});
      check("lu_stall_lo", {31'd0, stall}, 32'd0);

      // A load to x0 never causes a stall.
      set_id(1'b1, LW, 32'h10C, 5'd1, 5'd2, 5'd0, 1'b0);
      cycle(st);
      set_id(1'b1, ADD, 32'h110, 5'd0, 5'd0, 5'd7, 1'b0);
      #1;
      check("x0_stall", {31'd0, stall}, 32'd0);
      cycle(st);
      check("x0_valid", {31'd0, ex_valid}, 32'd1);

      // A flush in the same cycle as a hazard wins over the hazard.
      set_id(1'b1, LW, 32'h114, 5'd1, 5'd2, 5'd7, 1'b0);
      cycle(st);
      set_id(1'b1, ADD, 32'h118, 5'd4, 5'd7, 5'd8, 1'b1);
      #1;
      check("fl_stall", {31'd0, stall}, 32'd0);
      cycle(st);
      check("fl_valid_ctrl", {11'd0, ex_valid, ex_ctrl}, 32'd0);

      // Async reset between edges while EX is valid and a stall is pending.
      set_id(1'b1, LW, 32'h11C, 5'd1, 5'd2, 5'd9, 1'b0);
      cycle(st);
      set_id(1'b1, ADD, 32'h120, 5'd9, 5'd1, 5'd10, 1'b0);
      #1;
      check("pre_rst_stall", {31'd0, stall}, 32'd1);
      do_reset();
      cycle(st);
      check("post_rst_load", {11'd0, ex_valid, ex_ctrl}, {11'd0, 1'b1, ADD});

      // Three separate load-use hazards from reset.
      set_id(1'b0, 20'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
      do_reset();
      for (int k = 0; k < 3; k++) begin
         set_id(1'b1, LW, 32'h200 + k * 16, 5'd1, 5'd2, 5'd11, 1'b0);
         cycle(st);
         set_id(1'b1, ADD, 32'h204 + k * 16, 5'd3, 5'd11, 5'd12, 1'b0);
         cycle(st);
         cycle(st);
      end
`ifdef ID_EX_STALL_CNT_EN
      check("cnt_three", stall_count, 32'd3);
`else
      check("cnt_three", stall_count, 32'd0);
`endif

      // Random traffic. After a stall, the ID inputs are held as an upstream hold would do.
      st = 1'b0;
      for (int n = 0; n < 300; n++) begin
         if (!st) begin
            set_id(($urandom_range(0, 3) != 0), $urandom, $urandom,
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
         end else begin
            ex_flush = ($urandom_range(0, 7) == 0);
         end
         cycle(st);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 id_valid  in  1  ID slot holds a real instruction.
REQ-004 id_ctrl  in  20  decoder bundle, MSB->LSB: alu_fun[3:0], alu_srcA[1:0], alu_srcB[2:0], rf_wr_sel[1:0], regWrite, memWrEn, memRdEn, csr_we, mret_ex, jump, pcSource[2:0].
REQ-005 id_pc  in  32  PC of ID instruction.
REQ-006 id_rs1_addr  in  5  ir[19:15].
REQ-007 id_rs2_addr  in  5  ir[24:20].
REQ-008 id_rd_addr  in  5  ir[11:7].
REQ-009 id_rs1_data  in  32  register file port 1.
REQ-010 id_rs2_data  in  32  register file port 2.
REQ-011 id_imm  in  32  sign-extended immediate.
REQ-012 ex_flush  in  1  taken branch/jump/mret resolved in EX; kill ID and EX contents.
REQ-013 stall  out  1  combinational; holds PC and IF/ID register when 1.
REQ-014 ex_valid  out  1  EX slot holds a real instruction.
REQ-015 ex_ctrl  out  20  registered id_ctrl, same packing.
REQ-016 ex_pc, ex_imm, ex_rs1_data, ex_rs2_data  out  32 each  registered copies.
REQ-017 ex_rs1_addr, ex_rs2_addr, ex_rd_addr  out  5 each  registered copies, for forwarding.
REQ-018 stall_count  out  32  load-use stall cycle counter (see Configuration).

Function
REQ-019 Load-use hazard: haz = ex_valid & ex_ctrl.memRdEn & (ex_rd_addr != 0) & id_valid & (ex_rd_addr == id_rs1_addr | ex_rd_addr == id_rs2_addr); rs usage not qualified (conservative).
REQ-020 stall SHALL equal haz & ~ex_flush, zero-latency combinational.
REQ-021 Each rising edge, priority: ex_flush, then haz, then normal load.
REQ-022 ex_flush=1: ex_valid<=0, ex_ctrl<=0; data/address fields don't-care but SHALL load normally.
REQ-023 haz=1 (no flush): bubble inserted, ex_valid<=0, ex_ctrl<=0; ID instruction re-presented next cycle by upstream hold.
REQ-024 Normal: ex_valid<=id_valid; ex_ctrl<=id_valid ? id_ctrl : 0; all other fields <= ID inputs.
REQ-025 Latency ID->EX exactly 1 cycle; back-to-back instructions SHALL sustain 1/cycle absent hazards.
REQ-026 ex_ctrl SHALL be all-zero whenever ex_valid=0 (no regWrite, memWrEn, memRdEn, csr_we, mret_ex, jump; pcSource=0).
REQ-027 A hazard stalls at most one cycle: the bubble clears ex_valid, so haz deasserts the following cycle.
REQ-028 x0 destination never causes a stall.

Reset
REQ-029 rst_n=0 SHALL immediately clear ex_valid, ex_ctrl, all ex_* data/address outputs and stall_count to 0; stall then evaluates 0.
REQ-030 Reset asserted mid-stall discards the bubble state; first edge after release performs a normal load.

Configuration
REQ-031 Macro ID_EX_STALL_CNT_EN defined: stall_count increments by 1 on each edge where stall=1, saturates at 32'hFFFF_FFFF, cleared only by reset.
REQ-032 Macro undefined: no counter register; stall_count tied to 0.

Verification
REQ-033 Normal: id_valid=1, id_ctrl=20'h0A5C3, id_pc=32'h100 -> next cycle ex_valid=1, ex_ctrl=20'h0A5C3, ex_pc=32'h100, stall=0.
REQ-034 Load-use: EX holds lw x5 (memRdEn=1, rd=5), ID add rs1=5 -> stall=1 one cycle, bubble (ex_valid=0, ex_ctrl=0), add enters EX next cycle, stall=0.
REQ-035 x0 load: EX lw rd=0, ID rs1=0 -> stall=0, no bubble.
REQ-036 Flush+hazard same cycle: ex_flush=1 with haz true -> stall=0, ex_valid=0, ex_ctrl=0 next cycle.
REQ-037 Async reset: rst_n low between edges while ex_valid=1 -> ex_valid, ex_ctrl, stall_count 0 before next edge.
REQ-038 With ID_EX_STALL_CNT_EN: three separate load-use hazards -> stall_count=3; without macro -> stall_count=0.
